valid_ready_source: RTL

//  - Transmitting (master) end of the valid/ready handshake: turns one burst command into N data beats on

---
 rtl/valid_ready_source_pkg.sv | 15 +
 rtl/valid_ready_source.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/valid_ready_source_pkg.sv
// Shared definitions for the valid/ready burst source: FSM encoding and default widths.
package valid_ready_source_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_GAP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/valid_ready_source.sv
// Master end of a valid/ready link: expands one burst command into len+1 beats of
// incrementing data, with optional idle gaps between beats, honouring downstream backpressure.
module valid_ready_source
    import valid_ready_source_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int GAP_W  = DEF_GAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic [GAP_W-1:0]  cmd_gap,
    output logic [DATA_W-1:0] data_down,
    output logic              valid_down,
    output logic              last_down,
    input  logic              ready_down,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat transfers at a rising edge where valid_down && ready_down;
    // valid_down, data_down and last_down hold until that edge. A command transfers
    // at a rising edge where cmd_valid && cmd_ready.

    state_t            r_state,     w_state_nxt;
    logic [LEN_W-1:0]  r_len,       w_len_nxt;
    logic [LEN_W-1:0]  r_beat_cnt,  w_beat_nxt;
    logic [DATA_W-1:0] r_seed,      w_seed_nxt;
    logic [GAP_W-1:0]  r_gap,       w_gap_nxt;
    logic [GAP_W-1:0]  r_gap_cnt,   w_gap_cnt_nxt;
    logic [DATA_W-1:0] r_data,      w_data_nxt;
    logic              r_valid,     w_valid_nxt;
    logic              r_last,      w_last_nxt;
    logic              r_cmd_ready, w_cmd_ready_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;

    logic              w_accept;
    logic              w_hs;
    logic [LEN_W-1:0]  w_beat_inc;

    // cmd_ready is only ever high in IDLE, so acceptance needs no state qualifier.
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_hs       = r_valid && ready_down;
    assign w_beat_inc = r_beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_seed      <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_seed      <= w_seed_nxt;
            r_gap       <= w_gap_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_beat_nxt    = r_beat_cnt;
        w_seed_nxt    = r_seed;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_len_nxt   = cmd_len;
                    w_seed_nxt  = cmd_seed;
                    w_gap_nxt   = cmd_gap;
                    w_beat_nxt  = '0;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = cmd_seed;
                    w_last_nxt  = (cmd_len == '0);
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                        if (r_gap == '0) begin
                            w_data_nxt = r_seed + DATA_W'(w_beat_inc);
                            w_last_nxt = (w_beat_inc == r_len);
                        end else begin
                            w_state_nxt   = ST_GAP;
                            w_gap_cnt_nxt = r_gap;
                            w_valid_nxt   = 1'b0;
                            w_last_nxt    = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                // beat_cnt already points at the next beat; reload its data on exit.
                w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = ST_SEND;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = r_seed + DATA_W'(r_beat_cnt);
                    w_last_nxt  = (r_beat_cnt == r_len);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_nxt      = (w_state_nxt == ST_DONE);
    end

    assign cmd_ready  = r_cmd_ready;
    assign data_down  = r_data;
    assign valid_down = r_valid;
    assign last_down  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule
